// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port: pipeline write-back first, buffered late loads in idle cycles.
// Latency 1 cycle grant-to-port; late_ready drops when the FIFO is full; stall_req requests pipeline freeze on starvation.
// Backpressure: late path via late_ready only; the pipeline is never backpressured directly, only asked to stall.
module wb_port_arbiter #(
    parameter int WORD_LENGTH  = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_wb_enable,
    input  logic [3:0]               pipe_wb_dest,
    input  logic [WORD_LENGTH-1:0]   pipe_wb_value,
    input  logic                     late_issue,
    input  logic [3:0]               late_issue_dest,
    input  logic                     late_valid,
    input  logic [3:0]               late_dest,
    input  logic [WORD_LENGTH-1:0]   late_value,
    output logic                     late_ready,
    output logic                     rf_wb_enable,
    output logic [3:0]               rf_wb_dest,
    output logic [WORD_LENGTH-1:0]   rf_wb_value,
    output logic [15:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     stall_req,
    output logic                     hazard_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [SW-1:0]    LIMIT_C = SW'(STARVE_LIMIT);

    logic [3:0]             mem_dest_q  [DEPTH];
    logic [3:0]             mem_dest_d  [DEPTH];
    logic [WORD_LENGTH-1:0] mem_value_q [DEPTH];
    logic [WORD_LENGTH-1:0] mem_value_d [DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   stall_q, stall_d;
    logic [15:0]            pending_q, pending_d;
    logic                   hazard_q, hazard_d;
    logic                   rf_en_q, rf_en_d;
    logic [3:0]             rf_dest_q, rf_dest_d;
    logic [WORD_LENGTH-1:0] rf_value_q, rf_value_d;

    logic fifo_empty;
    logic push;
    logic pop;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;

    always_comb begin
        fifo_empty = (count_q == '0);
        late_ready = (count_q < DEPTH_C);
        push       = late_valid & late_ready;
        // Pop only looks at pre-edge occupancy, so a fresh push never bypasses to the port.
        pop        = ~pipe_wb_enable & ~fifo_empty;
    end

    always_comb begin
        mem_dest_d  = mem_dest_q;
        mem_value_d = mem_value_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            mem_dest_d[wr_ptr_q]  = late_dest;
            mem_value_d[wr_ptr_q] = late_value;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        rf_en_d    = 1'b0;
        rf_dest_d  = rf_dest_q;
        rf_value_d = rf_value_q;
        if (pipe_wb_enable) begin
            rf_en_d    = 1'b1;
            rf_dest_d  = pipe_wb_dest;
            rf_value_d = pipe_wb_value;
        end else if (pop) begin
            rf_en_d    = 1'b1;
            rf_dest_d  = mem_dest_q[rd_ptr_q];
            rf_value_d = mem_value_q[rd_ptr_q];
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (late_issue) begin
            set_mask = 16'(1) << late_issue_dest;
        end
        if (pop) begin
            clr_mask = 16'(1) << mem_dest_q[rd_ptr_q];
        end
        // A set in the same cycle as a clear of that bit must survive.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        hazard_d  = hazard_q
                  | (late_issue & pending_q[late_issue_dest])
                  | (pipe_wb_enable & pending_q[pipe_wb_dest]);
    end

    always_comb begin
        starve_d = '0;
        if (!fifo_empty && pipe_wb_enable) begin
            starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + SW'(1);
        end
        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_q == LIMIT_C) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_dest_q[i]  <= '0;
                mem_value_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            pending_q  <= '0;
            hazard_q   <= 1'b0;
            rf_en_q    <= 1'b0;
            rf_dest_q  <= '0;
            rf_value_q <= '0;
        end else begin
            mem_dest_q  <= mem_dest_d;
            mem_value_q <= mem_value_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            pending_q   <= pending_d;
            hazard_q    <= hazard_d;
            rf_en_q     <= rf_en_d;
            rf_dest_q   <= rf_dest_d;
            rf_value_q  <= rf_value_d;
        end
    end

    assign rf_wb_enable = rf_en_q;
    assign rf_wb_dest   = rf_dest_q;
    assign rf_wb_value  = rf_value_q;
    assign pending_mask = pending_q;
    assign fifo_count   = count_q;
    assign stall_req    = stall_q;
    assign hazard_err   = hazard_q;

endmodule
